// File: rtl/mac_out_serializer_if.sv
// Handshake/bus bundle between the 512-bit accumulator side and the word-serial output side.
// Latency: n/a (wires only).
// Backpressure: out_ready is the only backpressure input; the capture side has none (cap_drop reports rejects).
//
// Signals:
//   cap, acc_in          capture strobe and 512-bit accumulator result
//   out_data, out_valid  current output word and its valid flag
//   out_ready            downstream accepts the word
//   out_last             final word of the frame
//   busy                 frame in progress
//   cap_drop             one-cycle pulse when a capture is rejected
// Modports: slave = serializer side, master = producer/consumer side.
interface mac_out_serializer_if #(
  parameter int WORD_W = 32
);
  logic              cap;
  logic [511:0]      acc_in;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              cap_drop;

  modport slave (
    input  cap, acc_in, out_ready,
    output out_data, out_valid, out_last, busy, cap_drop
  );

  modport master (
    output cap, acc_in, out_ready,
    input  out_data, out_valid, out_last, busy, cap_drop
  );
endinterface

// File: rtl/mac_out_serializer.sv
// Serializes a captured 512-bit accumulator result into NWORDS words of WORD_W bits, LSW first.
// Latency: first word valid one cycle after an accepted cap; a frame takes >= NWORDS cycles (+1 with checksum).
// Backpressure: out_ready low holds out_data/out_last/index; caps arriving mid-frame are dropped with cap_drop.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mac_out_serializer_if.slave (cap, acc_in, out_ready in; out_data, out_valid, out_last, busy, cap_drop out)
// Optional feature: define MAC_SER_CKSUM_EN to append an XOR checksum word to each frame.
module mac_out_serializer #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_out_serializer_if.slave   bus
);

  localparam int NWORDS = 512 / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

`ifdef MAC_SER_CKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CKSUM} state_t;
`else
  typedef enum logic {ST_IDLE, ST_SEND} state_t;
`endif

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             idx_d;
  logic [NWORDS-1:0][WORD_W-1:0] shadow_q;
  logic [WORD_W-1:0]            out_data_q;
  logic                         out_valid_q;
  logic                         out_last_q;
  logic                         cap_drop_q;
`ifdef MAC_SER_CKSUM_EN
  logic [WORD_W-1:0]            cksum_q;
  logic [WORD_W-1:0]            cksum_d;
`endif

  logic xfer;
  logic frame_end;
  logic accept;

  assign xfer      = out_valid_q & bus.out_ready;
  // out_last is registered with the word, so a handshake on it is the frame's final one.
  assign frame_end = xfer & out_last_q;
  assign accept    = bus.cap & ((state_q == ST_IDLE) | frame_end);
  assign idx_d     = idx_q + 1'b1;
`ifdef MAC_SER_CKSUM_EN
  // Running XOR of every data word already handed over, including the one on the bus now.
  assign cksum_d   = cksum_q ^ out_data_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cap_drop_q  <= 1'b0;
`ifdef MAC_SER_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      cap_drop_q <= bus.cap & ~accept;
      if (accept) begin
        // Word 0 comes straight from acc_in so it is on the bus the cycle after cap.
        state_q     <= ST_SEND;
        idx_q       <= '0;
        shadow_q    <= bus.acc_in;
        out_data_q  <= bus.acc_in[WORD_W-1:0];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
`ifdef MAC_SER_CKSUM_EN
        cksum_q     <= '0;
`endif
      end else if (xfer) begin
        case (state_q)
          ST_SEND: begin
            if (idx_q == LAST_IDX) begin
`ifdef MAC_SER_CKSUM_EN
              state_q    <= ST_CKSUM;
              out_data_q <= cksum_d;
              out_last_q <= 1'b1;
              cksum_q    <= cksum_d;
`else
              state_q     <= ST_IDLE;
              out_data_q  <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
`endif
            end else begin
              idx_q      <= idx_d;
              out_data_q <= shadow_q[idx_d];
`ifdef MAC_SER_CKSUM_EN
              cksum_q    <= cksum_d;
`else
              out_last_q <= (idx_d == LAST_IDX);
`endif
            end
          end
          default: begin
            // Checksum word accepted (or an unreachable state): frame over.
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.cap_drop  = cap_drop_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mac_out_serializer.md
MAC_OUT_SERIALIZER -- requirements
Module: mac_out_serializer

Interface
REQ-001 Parameter: WORD_W, 32, output word width; legal values 8, 16, 32, 64, 128.
REQ-002 Parameter: NWORDS, 512/WORD_W, words per accumulator result; derived, never overridden.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: cap  input  1  capture strobe for acc_in.
REQ-006 Port: acc_in  input  512  accumulator result from MAC_512 acc_out.
REQ-007 Port: out_data  output  WORD_W  current output word.
REQ-008 Port: out_valid  output  1  out_data holds a valid word.
REQ-009 Port: out_ready  input  1  downstream accepts the word.
REQ-010 Port: out_last  output  1  current word is the final word of the frame.
REQ-011 Port: busy  output  1  frame in progress (state != IDLE).
REQ-012 Port: cap_drop  output  1  one-cycle pulse when a cap is rejected.

Function
REQ-013 The FSM SHALL have the states IDLE and SEND, plus CKSUM when MAC_SER_CKSUM_EN is defined.
REQ-014 When cap=1 and the capture is accepted, the block SHALL latch acc_in into a 512-bit shadow register, clear the word index, and enter SEND on the next edge.
REQ-015 A capture SHALL be accepted when the FSM is in IDLE, or in the same cycle as the final handshake of a frame (back-to-back frames, no bubble).
REQ-016 A cap in any other cycle SHALL be ignored, leave the shadow register unchanged, and pulse cap_drop high for exactly one cycle.
REQ-017 In SEND, out_valid SHALL be 1, and out_data SHALL equal shadow[index*WORD_W +: WORD_W], least-significant word first.
REQ-018 A transfer SHALL occur on a cycle where out_valid=1 and out_ready=1; on a transfer, index increments by 1.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_last and index SHALL hold stable.
REQ-020 out_last SHALL be 1 only on the final word of a frame: index NWORDS-1 without the checksum, or the CKSUM word with it.
REQ-021 After the final transfer, the FSM SHALL return to IDLE and out_valid SHALL be 0 on the next cycle, unless a back-to-back capture occurred.
REQ-022 The first word SHALL be valid one cycle after the accepted cap; the minimum frame duration is NWORDS cycles (NWORDS+1 with the checksum).
REQ-023 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-024 In IDLE, out_data SHALL be driven to 0.

Reset
REQ-025 On a clk edge with rst_n=0, the block SHALL set: state IDLE, index 0, shadow register 0, out_valid 0, out_last 0, busy 0, cap_drop 0, out_data 0, checksum accumulator 0.
REQ-026 Reset SHALL take priority over cap and out_ready in the same cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame; no further words of that frame are emitted after reset deasserts.

Configuration
REQ-028 With the macro MAC_SER_CKSUM_EN defined, after word NWORDS-1 transfers the block SHALL enter CKSUM and emit one extra word equal to the XOR of all NWORDS data words, with out_last=1.
REQ-029 Without MAC_SER_CKSUM_EN, the CKSUM state and the checksum logic SHALL be absent, and out_last SHALL mark word NWORDS-1.

Verification
REQ-030 The bench SHALL cover each of the following scenarios (WORD_W=32, NWORDS=16):
- Basic frame: reset, then acc_in word i = i+1, cap pulse, out_ready=1 -> 16 words 0x00000001..0x00000010 on consecutive cycles, starting 1 cycle after cap; out_last only on 0x00000010; busy drops after the frame.
- Backpressure: same frame, out_ready toggled 1,0,0,1,... -> no word duplicated or lost, and out_data stable during stalls.
- Drop: cap pulsed again at word 5 with acc_in all-ones -> cap_drop pulses one cycle; the remaining words are still 0x00000006..0x00000010.
- Back-to-back: cap with a new acc_in (word i = 0xA0+i) on the final-handshake cycle -> the next frame starts the following cycle with no out_valid gap; cap_drop stays 0.
- Reset mid-frame: rst_n=0 for one cycle at word 8 -> out_valid=0 and busy=0 the next cycle; no further words emitted until a new cap.
- Checksum: MAC_SER_CKSUM_EN defined, basic frame -> 17th word 0x00000010 (XOR of 1..16) with out_last=1, and out_last=0 on word 16.
